// File: rtl/countdown_sprite_reader.sv
// Countdown sprite reader: scan-position to ROM address generation, ROM latency
// compensation and frame-synchronous "3-2-1" digit sequencing.
//
// state | meaning
// IDLE  | waiting for start; pend_q remembers a start until the next frame
// THREE | showing "3" for FRAMES_PER_DIGIT frames
// TWO   | showing "2"
// ONE   | showing "1"
// DONE  | countdown finished; next frame_start returns to IDLE
module countdown_sprite_reader #(
  parameter int SPRITE_W         = 60,
  parameter int SPRITE_H         = 60,
  parameter int POS_X            = 290,
  parameter int POS_Y            = 210,
  parameter int FRAMES_PER_DIGIT = 60
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [4:0]  data_In_three,
  input  logic [4:0]  data_In_two,
  input  logic [4:0]  data_In_one,
  output logic [11:0] read_address,
  output logic        pixel_on,
  output logic [4:0]  palette_idx,
  output logic        busy,
  output logic        countdown_done
);

  typedef enum logic [2:0] {S_IDLE, S_THREE, S_TWO, S_ONE, S_DONE} state_t;
  typedef enum logic [1:0] {DIG_NONE, DIG_THREE, DIG_TWO, DIG_ONE} digit_t;

  // 11-bit bounds so POS + SIZE never wraps
  localparam logic [10:0] X_LO = 11'(POS_X);
  localparam logic [10:0] X_HI = 11'(POS_X + SPRITE_W);
  localparam logic [10:0] Y_LO = 11'(POS_Y);
  localparam logic [10:0] Y_HI = 11'(POS_Y + SPRITE_H);
  localparam logic [7:0]  CNT_LAST = 8'(FRAMES_PER_DIGIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        done_q, done_d;

  digit_t      cur_dig;
  logic [10:0] dx, dy, rel_x, rel_y;
  logic        in_box;
  logic [11:0] addr_d, addr_q;
  logic        inbox1_q, inbox2_q;
  digit_t      dig1_q, dig2_q;
  logic [4:0]  rom_idx;
  logic        pix_d, pix_q;
  logic [4:0]  idx_d, idx_q;

  // Sequencer state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  // Sequencer next state: digits only advance on frame boundaries
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q && frame_start) begin
          state_d = S_THREE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (start) begin
          pend_d = 1'b1;
        end
      end
      S_THREE, S_TWO, S_ONE: begin
        if (frame_start) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (state_q)
              S_THREE: state_d = S_TWO;
              S_TWO:   state_d = S_ONE;
              default: begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        if (frame_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Digit select seen by the address stage, and scan-position decode
  always_comb begin
    case (state_q)
      S_THREE: cur_dig = DIG_THREE;
      S_TWO:   cur_dig = DIG_TWO;
      S_ONE:   cur_dig = DIG_ONE;
      default: cur_dig = DIG_NONE;
    endcase
    dx     = {1'b0, DrawX};
    dy     = {1'b0, DrawY};
    in_box = (dx >= X_LO) && (dx < X_HI) && (dy >= Y_LO) && (dy < Y_HI);
    rel_x  = dx - X_LO;
    rel_y  = dy - Y_LO;
    addr_d = in_box ? (12'(rel_y) * 12'(SPRITE_W) + 12'(rel_x)) : 12'd0;
  end

  // Address, ROM-wait and output pipeline; reset drops every valid
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q   <= '0;
      inbox1_q <= 1'b0;
      dig1_q   <= DIG_NONE;
      inbox2_q <= 1'b0;
      dig2_q   <= DIG_NONE;
      pix_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      inbox1_q <= in_box;
      dig1_q   <= cur_dig;
      inbox2_q <= inbox1_q;
      dig2_q   <= dig1_q;
      pix_q    <= pix_d;
      idx_q    <= idx_d;
    end
  end

  // Pick the ROM for the digit that was sampled with this pixel; index 0 is transparent
  always_comb begin
    case (dig2_q)
      DIG_THREE: rom_idx = data_In_three;
      DIG_TWO:   rom_idx = data_In_two;
      DIG_ONE:   rom_idx = data_In_one;
      default:   rom_idx = 5'd0;
    endcase
    pix_d = inbox2_q && (dig2_q != DIG_NONE) && (rom_idx != 5'd0);
    idx_d = pix_d ? rom_idx : 5'd0;
  end

  assign read_address   = addr_q;
  assign pixel_on       = pix_q;
  assign palette_idx    = idx_q;
  assign busy           = (state_q == S_THREE) || (state_q == S_TWO) || (state_q == S_ONE);
  assign countdown_done = done_q;

endmodule

// File: tb/tb_countdown_sprite_reader.sv
// Bench for countdown_sprite_reader: directed literal checks plus random
// stimulus compared every cycle against a frame-count based model.
module tb_countdown_sprite_reader;

  localparam int F    = 2;
  localparam int MAXC = 6000;

  logic        Clk = 1'b0;
  logic        Reset, start, frame_start;
  logic [9:0]  DrawX, DrawY;
  logic [4:0]  data_In_three, data_In_two, data_In_one;
  logic [11:0] read_address;
  logic        pixel_on;
  logic [4:0]  palette_idx;
  logic        busy, countdown_done;

  countdown_sprite_reader #(
    .SPRITE_W(60), .SPRITE_H(60), .POS_X(290), .POS_Y(210), .FRAMES_PER_DIGIT(F)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY),
    .data_In_three(data_In_three), .data_In_two(data_In_two), .data_In_one(data_In_one),
    .read_address(read_address), .pixel_on(pixel_on), .palette_idx(palette_idx),
    .busy(busy), .countdown_done(countdown_done)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // per-edge history: reset, in-box, expected address, digit, ROM force value
  int a_rst  [0:MAXC];
  int a_in   [0:MAXC];
  int a_addr [0:MAXC];
  int a_dig  [0:MAXC];
  int a_frc  [0:MAXC];

  // model: mode 0 idle, 1 counting frames, 2 done; k = frames since countdown began
  int m_mode = 0;
  int m_k    = 0;
  int m_pend = 0;
  int prev_addr = 0;
  int force_val = -1;

  function automatic int rom(int d, int a);
    if (a % 5 == 0) return 0;
    return (a * 7 + d * 11) % 32;
  endfunction

  function automatic int in_box(int x, int y);
    return (x >= 290 && x < 350 && y >= 210 && y < 270) ? 1 : 0;
  endfunction

  function automatic int model_digit();
    if (m_mode != 1) return 0;
    if (m_k < F)     return 3;
    if (m_k < 2 * F) return 2;
    return 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f, input int x, input int y);
    int inb, dg, exp_busy, exp_done, ep, ei, v;
    Reset = r; start = s; frame_start = f;
    DrawX = 10'(x); DrawY = 10'(y);
    @(posedge Clk);
    #1;
    cyc++;
    inb = in_box(x, y);
    dg  = model_digit();
    a_rst[cyc]  = r;
    a_in[cyc]   = inb;
    a_addr[cyc] = (r || !inb) ? 0 : ((y - 210) * 60 + (x - 290)) % 4096;
    a_dig[cyc]  = dg;

    exp_done = 0;
    if (r) begin
      m_mode = 0; m_k = 0; m_pend = 0;
    end else begin
      case (m_mode)
        0: begin
          if (m_pend && f) begin m_mode = 1; m_k = 0; m_pend = 0; end
          else if (s) m_pend = 1;
        end
        1: begin
          if (f) begin
            m_k++;
            if (m_k == 3 * F) begin m_mode = 2; m_k = 0; exp_done = 1; end
          end
        end
        default: if (f) m_mode = 0;
      endcase
    end
    exp_busy = (m_mode == 1) ? 1 : 0;

    ep = 0; ei = 0;
    if (cyc >= 3 && !a_rst[cyc] && !a_rst[cyc-1] && !a_rst[cyc-2] &&
        a_in[cyc-2] != 0 && a_dig[cyc-2] != 0) begin
      v = (a_frc[cyc-1] >= 0) ? a_frc[cyc-1] : rom(a_dig[cyc-2], a_addr[cyc-2]);
      if (v != 0) begin ep = 1; ei = v; end
    end

    chk("read_address", read_address, a_addr[cyc]);
    chk("pixel_on", pixel_on, ep);
    chk("palette_idx", palette_idx, ei);
    chk("busy", busy, exp_busy);
    chk("countdown_done", countdown_done, exp_done);

    // registered ROMs: data now visible was addressed by the previous read_address
    a_frc[cyc] = force_val;
    data_In_three = 5'((force_val >= 0) ? force_val : rom(3, prev_addr));
    data_In_two   = 5'((force_val >= 0) ? force_val : rom(2, prev_addr));
    data_In_one   = 5'((force_val >= 0) ? force_val : rom(1, prev_addr));
    prev_addr = read_address;
  endtask

  initial begin
    for (int i = 0; i <= MAXC; i++) begin
      a_rst[i] = 0; a_in[i] = 0; a_addr[i] = 0; a_dig[i] = 0; a_frc[i] = -1;
    end
    Reset = 1'b1; start = 1'b0; frame_start = 1'b0; DrawX = '0; DrawY = '0;
    data_In_three = '0; data_In_two = '0; data_In_one = '0;

    // reset with arbitrary inputs
    step(1, 1, 1, 300, 220);
    step(1, 1, 0, 320, 230);
    chk("rst_addr", read_address, 0);
    chk("rst_pixel", pixel_on, 0);
    chk("rst_idx", palette_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", countdown_done, 0);

    // address generation corners
    step(0, 0, 0, 290, 210);
    chk("lit_addr_origin", read_address, 0);
    step(0, 0, 0, 349, 269);
    chk("lit_addr_last", read_address, 3599);
    step(0, 0, 0, 350, 269);
    chk("lit_addr_outside", read_address, 0);

    // enter THREE
    step(0, 1, 0, 0, 0);
    chk("lit_busy_pending", busy, 0);
    step(0, 0, 1, 0, 0);
    chk("lit_busy_three", busy, 1);

    // latency and transparency
    force_val = 7;
    step(0, 0, 0, 300, 215);
    step(0, 0, 0, 0, 0);
    chk("lit_pixel_early", pixel_on, 0);
    step(0, 0, 0, 0, 0);
    chk("lit_pixel_lat3", pixel_on, 1);
    chk("lit_idx_lat3", palette_idx, 7);
    force_val = 0;
    step(0, 0, 0, 300, 215);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("lit_pixel_transp", pixel_on, 0);
    chk("lit_idx_transp", palette_idx, 0);
    force_val = -1;

    // sequencing with an ignored start in TWO
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("lit_busy_two", busy, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("lit_done_early", countdown_done, 0);
    step(0, 0, 1, 0, 0);
    chk("lit_done_pulse", countdown_done, 1);
    chk("lit_busy_done", busy, 0);
    step(0, 0, 0, 0, 0);
    chk("lit_done_once", countdown_done, 0);
    step(0, 0, 1, 0, 0);

    // start coincident with frame_start in IDLE defers by one frame
    step(0, 1, 1, 0, 0);
    chk("lit_defer_idle", busy, 0);
    step(0, 0, 1, 0, 0);
    chk("lit_defer_three", busy, 1);

    // reset during ONE with an in-box pixel in flight
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    chk("lit_busy_one", busy, 1);
    force_val = 9;
    step(0, 0, 0, 320, 240);
    step(1, 0, 0, 0, 0);
    chk("lit_rst_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("lit_drain_pixel", pixel_on, 0);
      chk("lit_drain_done", countdown_done, 0);
    end
    force_val = -1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int x, y;
      bit r, s, f;
      if ($urandom_range(0, 9) == 0) begin
        x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
      end else begin
        x = $urandom_range(280, 360); y = $urandom_range(200, 280);
      end
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 19) == 0);
      f = ($urandom_range(0, 7) == 0);
      step(r, s, f, x, y);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
